// File: rtl/raw_hazard_detect_if.sv
// ============================================================================
// Module      : raw_hazard_detect_if
// Description : Decode-side bus for the RAW hazard detector. It carries the
//               decode instruction's register usage and returns the stall
//               request, the EX/MEM/WB writer slots and the stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface raw_hazard_detect_if #(
  parameter int CNT_W = 8
);
  // Decode instruction description
  logic             idValid;
  logic             idRsUse;
  logic [2:0]       idRs;
  logic             idRtUse;
  logic [2:0]       idRt;
  logic             idWrEn;
  logic [2:0]       idRd;
  logic             idIsLoad;
  logic             flush;

  // Hazard result and in-flight writer slots
  logic             stall;
  logic             exValid;
  logic [2:0]       exRd;
  logic             memValid;
  logic [2:0]       memRd;
  logic             wbValid;
  logic [2:0]       wbRd;
  logic [CNT_W-1:0] stallCnt;

  // Decode stage side: describes the instruction, consumes the stall
  modport master (
    output idValid, idRsUse, idRs, idRtUse, idRt, idWrEn, idRd, idIsLoad, flush,
    input  stall, exValid, exRd, memValid, memRd, wbValid, wbRd, stallCnt
  );

  // Hazard detector side
  modport slave (
    input  idValid, idRsUse, idRs, idRtUse, idRt, idWrEn, idRd, idIsLoad, flush,
    output stall, exValid, exRd, memValid, memRd, wbValid, wbRd, stallCnt
  );
endinterface

`default_nettype wire

// File: rtl/raw_hazard_detect.sv
// ============================================================================
// Module      : raw_hazard_detect
// Description : Read-after-write hazard detector beside decode. Tracks the
//               destination register of every writer in EX, MEM and WB,
//               compares against the decode sources, raises a combinational
//               decode stall and turns the stalled slot into an EX bubble.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module raw_hazard_detect #(
  parameter int FORWARD_EN = 0,
  parameter int CNT_W      = 8
) (
  input  logic               clk,
  input  logic               rst,   // synchronous, active-low
  raw_hazard_detect_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Writer slots. Only EX needs the load flag: with forwarding, a load is the
  // sole producer whose result is not ready for the next instruction, and it
  // is only ever checked while it sits in EX.
  logic             ex_v;
  logic [2:0]       ex_rd;
  logic             ex_ld;
  logic             mem_v;
  logic [2:0]       mem_rd;
  logic             wb_v;
  logic [2:0]       wb_rd;
  logic [CNT_W-1:0] cnt;

  logic match_ex;
  logic match_mem;
  logic hazard;
  logic stall;

  // Source/destination comparison against the EX and MEM writers
  always_comb begin
    match_ex  = ex_v  & ((bus.idRsUse & (bus.idRs == ex_rd))  |
                         (bus.idRtUse & (bus.idRt == ex_rd)));
    match_mem = mem_v & ((bus.idRsUse & (bus.idRs == mem_rd)) |
                         (bus.idRtUse & (bus.idRt == mem_rd)));
  end

  // WB never stalls: the register file bypasses its write to a same-cycle read
  generate
    if (FORWARD_EN != 0) begin : g_fwd
      assign hazard = match_ex & ex_ld;
    end else begin : g_nofwd
      assign hazard = match_ex | match_mem;
    end
  endgenerate

  // A flushed or empty decode slot can never stall
  assign stall = bus.idValid & ~bus.flush & hazard;

  // Slot pipeline and saturating stall counter; the back end never stalls
  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_v   <= 1'b0;
      ex_rd  <= 3'd0;
      ex_ld  <= 1'b0;
      mem_v  <= 1'b0;
      mem_rd <= 3'd0;
      wb_v   <= 1'b0;
      wb_rd  <= 3'd0;
      cnt    <= '0;
    end else begin
      // rd/ld follow decode even on a bubble; only the valid bit is gated
      ex_v   <= bus.idValid & bus.idWrEn & ~stall & ~bus.flush;
      ex_rd  <= bus.idRd;
      ex_ld  <= bus.idIsLoad;
      mem_v  <= ex_v;
      mem_rd <= ex_rd;
      wb_v   <= mem_v;
      wb_rd  <= mem_rd;
      if (stall && (cnt != CNT_MAX)) begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

  assign bus.stall    = stall;
  assign bus.exValid  = ex_v;
  assign bus.exRd     = ex_rd;
  assign bus.memValid = mem_v;
  assign bus.memRd    = mem_rd;
  assign bus.wbValid  = wb_v;
  assign bus.wbRd     = wb_rd;
  assign bus.stallCnt = cnt;

endmodule

`default_nettype wire

// File: tb/tb_raw_hazard_detect.sv
// ============================================================================
// Module      : tb_raw_hazard_detect
// Description : Directed bench for raw_hazard_detect. Three instances share
//               one stimulus stream: no forwarding (dut0), forwarding (dut1)
//               and no forwarding with a 2-bit counter (dut2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_raw_hazard_detect;

  logic       clk = 1'b0;
  logic       rst;
  logic       idValid, idRsUse, idRtUse, idWrEn, idIsLoad, flush;
  logic [2:0] idRs, idRt, idRd;

  int total = 0;
  int bad   = 0;

  raw_hazard_detect_if #(.CNT_W(8)) if0 ();
  raw_hazard_detect_if #(.CNT_W(8)) if1 ();
  raw_hazard_detect_if #(.CNT_W(2)) if2 ();

  // Fan the shared stimulus out to every instance
  assign if0.idValid = idValid;  assign if1.idValid = idValid;  assign if2.idValid = idValid;
  assign if0.idRsUse = idRsUse;  assign if1.idRsUse = idRsUse;  assign if2.idRsUse = idRsUse;
  assign if0.idRs    = idRs;     assign if1.idRs    = idRs;     assign if2.idRs    = idRs;
  assign if0.idRtUse = idRtUse;  assign if1.idRtUse = idRtUse;  assign if2.idRtUse = idRtUse;
  assign if0.idRt    = idRt;     assign if1.idRt    = idRt;     assign if2.idRt    = idRt;
  assign if0.idWrEn  = idWrEn;   assign if1.idWrEn  = idWrEn;   assign if2.idWrEn  = idWrEn;
  assign if0.idRd    = idRd;     assign if1.idRd    = idRd;     assign if2.idRd    = idRd;
  assign if0.idIsLoad = idIsLoad; assign if1.idIsLoad = idIsLoad; assign if2.idIsLoad = idIsLoad;
  assign if0.flush   = flush;    assign if1.flush   = flush;    assign if2.flush   = flush;

  raw_hazard_detect #(.FORWARD_EN(0), .CNT_W(8)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  raw_hazard_detect #(.FORWARD_EN(1), .CNT_W(8)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  raw_hazard_detect #(.FORWARD_EN(0), .CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));

  // Free-running clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle a little after it
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    idValid = 0; idRsUse = 0; idRs = 0; idRtUse = 0; idRt = 0;
    idWrEn = 0; idRd = 0; idIsLoad = 0; flush = 0;
  endtask

  task automatic writer(input logic [2:0] rd, input logic ld);
    idle();
    idValid = 1; idWrEn = 1; idRd = rd; idIsLoad = ld;
  endtask

  task automatic do_reset();
    idle();
    rst = 0;
    tick();
    rst = 1;
  endtask

  initial begin
    // ---- 1: reset with a writer presented ----
    rst = 0;
    writer(3'd5, 1'b0);
    tick();
    tick();
    #1;
    chk("rst_exValid",  if0.exValid,  0);
    chk("rst_memValid", if0.memValid, 0);
    chk("rst_wbValid",  if0.wbValid,  0);
    chk("rst_stall",    if0.stall,    0);
    chk("rst_cnt",      if0.stallCnt, 0);
    rst = 1;
    tick();
    chk("post_rst_exValid", if0.exValid, 1);
    chk("post_rst_exRd",    if0.exRd,    5);
    chk("post_rst_exValid_fwd", if1.exValid, 1);

    // ---- 2: back-to-back RAW, no forwarding ----
    do_reset();
    writer(3'd3, 1'b0);
    tick();
    writer(3'd7, 1'b0);
    idRsUse = 1; idRs = 3;
    #1;
    chk("raw_stall_c1", if0.stall, 1);
    chk("raw_fwd_nostall", if1.stall, 0);
    tick();
    chk("raw_bubble1", if0.exValid, 0);
    chk("raw_stall_c2", if0.stall,  1);
    tick();
    chk("raw_bubble2", if0.exValid, 0);
    chk("raw_stall_c3", if0.stall,  0);
    tick();
    chk("raw_accept_v",  if0.exValid,  1);
    chk("raw_accept_rd", if0.exRd,     7);
    chk("raw_cnt",       if0.stallCnt, 2);

    // ---- 3a: load-use with forwarding ----
    do_reset();
    writer(3'd2, 1'b1);
    tick();
    idle();
    idValid = 1; idRtUse = 1; idRt = 2;
    #1;
    chk("ld_use_stall", if1.stall, 1);
    tick();
    chk("ld_use_bubble",  if1.exValid, 0);
    chk("ld_use_release", if1.stall,   0);
    chk("ld_use_cnt",     if1.stallCnt, 1);

    // ---- 3b: same sequence, non-load producer ----
    do_reset();
    writer(3'd2, 1'b0);
    tick();
    idle();
    idValid = 1; idRtUse = 1; idRt = 2;
    #1;
    chk("alu_use_stall", if1.stall, 0);
    tick();
    chk("alu_use_cnt", if1.stallCnt, 0);

    // ---- 4: flush beats hazard ----
    do_reset();
    writer(3'd4, 1'b0);
    tick();
    writer(3'd1, 1'b0);
    idRsUse = 1; idRs = 4; flush = 1;
    #1;
    chk("flush_stall", if0.stall, 0);
    tick();
    chk("flush_exValid", if0.exValid,  0);
    chk("flush_cnt",     if0.stallCnt, 0);
    // producer now in MEM, but an empty decode slot never stalls
    idle();
    idRsUse = 1; idRs = 4;
    #1;
    chk("novalid_stall", if0.stall, 0);

    // ---- 5: match only against WB ----
    do_reset();
    writer(3'd6, 1'b0);
    tick();
    writer(3'd1, 1'b0);
    tick();
    writer(3'd2, 1'b0);
    tick();
    idle();
    idValid = 1; idRsUse = 1; idRs = 6;
    #1;
    chk("wb_stall",   if0.stall,   0);
    chk("wb_rd",      if0.wbRd,    6);
    chk("wb_valid",   if0.wbValid, 1);
    chk("wb_mem_rd",  if0.memRd,   1);
    chk("wb_ex_rd",   if0.exRd,    2);

    // ---- 6: 2-bit counter saturation, then reset mid-stall ----
    do_reset();
    writer(3'd3, 1'b0);
    tick();
    writer(3'd3, 1'b0);
    idRsUse = 1; idRs = 3;
    tick();                       // stall edge 1
    chk("sat_1", if2.stallCnt, 1);
    tick();                       // stall edge 2
    chk("sat_2", if2.stallCnt, 2);
    tick();                       // accept
    tick();                       // stall edge 3
    chk("sat_3", if2.stallCnt, 3);
    tick();                       // stall edge 4
    chk("sat_4", if2.stallCnt, 3);
    tick();                       // accept
    tick();                       // stall edge 5
    chk("sat_5", if2.stallCnt, 3);
    #1;
    chk("sat_midstall", if2.stall, 1);
    rst = 0;
    tick();
    chk("rst_mid_stall",   if2.stall,    0);
    chk("rst_mid_cnt",     if2.stallCnt, 0);
    chk("rst_mid_exValid", if2.exValid,  0);
    chk("rst_mid_memValid", if2.memValid, 0);
    rst = 1;
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/raw_hazard_detect.md
Name: raw_hazard_detect

Overview:
- Tracks the 3-bit destination register number and write-valid of every in-flight instruction across the EX, MEM and WB slots.
- Compares these slots against the source registers of the instruction in decode and asserts a decode stall on a read-after-write hazard.
- On a stall it inserts a bubble into EX.
- Sits beside decode; its EX/MEM/WB destination outputs drive the pipeline's 3-bit destination registers and the register-file write port.

Parameters:
- FORWARD_EN, 0, 0 = no forwarding (stall on any EX/MEM match); 1 = forwarding exists (stall only on load-use in EX).
- CNT_W, 8, width of the saturating stall-cycle counter.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous reset, active-low (rst==0 at a rising edge resets)
- idValid  input  1  decode holds a real instruction
- idRsUse  input  1  decode instruction reads Rs
- idRs  input  3  Rs number
- idRtUse  input  1  decode instruction reads Rt
- idRt  input  3  Rt number
- idWrEn  input  1  decode instruction writes a register
- idRd  input  3  decode destination register
- idIsLoad  input  1  decode instruction is a load
- flush  input  1  branch/jump redirect; kills the decode instruction
- stall  output  1  hold PC and IF/ID this cycle
- exValid, memValid, wbValid  output  1 each  slot holds a register writer
- exRd, memRd, wbRd  output  3 each  slot destination register
- stallCnt  output  CNT_W  saturating count of stall cycles

Behaviour:
- State: three slots {v, rd[2:0], ld}, EX→MEM→WB, plus stallCnt.
- Reset (rst==0 at edge): all v=0, rd=0, ld=0, stallCnt=0. stall therefore reads 0 in the first cycle after reset.
- Reset mid-operation discards all in-flight slots. No hazard survives reset.
- Match conditions:
  - matchX(slot) = slot.v & ((idRsUse & idRs==slot.rd) | (idRtUse & idRt==slot.rd)).
  - R0 is an ordinary register; no special case.
- stall is combinational, registered nowhere:
  - FORWARD_EN=0: stall = idValid & ~flush & (matchX(EX) | matchX(MEM)).
  - FORWARD_EN=1: stall = idValid & ~flush & matchX(EX) & EX.ld.
  - WB never causes a stall; the register file bypasses the write to the same-cycle read.
- Slot update each edge when rst==1:
  - EX ← {idValid & idWrEn & ~stall & ~flush, idRd, idIsLoad}. On a bubble, rd and ld take the inputs but v=0.
  - MEM ← EX and WB ← MEM unconditionally; the back end never stalls.
- Latency:
  - A writer accepted at edge N occupies EX during cycle N+1, MEM during N+2 and WB during N+3, then is gone.
  - FORWARD_EN=0: a dependent instruction held in decode stalls 2 cycles when it immediately follows its producer, 1 cycle with one instruction between, 0 with two.
  - FORWARD_EN=1: a load followed immediately by its consumer stalls exactly 1 cycle.
- Simultaneous flush and hazard: flush wins; stall=0 and no writer enters EX.
- idValid=0: stall=0 and a bubble enters EX.
- Matches in both EX and MEM produce a single stall signal, not a count of two.
- stallCnt: +1 on each edge where stall==1 and rst==1; holds at 2^CNT_W−1 (255 by default), no wrap.
- Outputs exValid/exRd etc. are direct slot contents: registered, no combinational path from inputs.

Test Plan:
1. Reset: hold rst=0 for 2 cycles with idValid=1, idWrEn=1, idRd=5 → all valids 0, stall=0, stallCnt=0. After release, exValid=1, exRd=5 one edge later.
2. Back-to-back RAW with FORWARD_EN=0: issue idRd=3 writer, then consumer idRs=3 held in decode → stall=1 for exactly 2 cycles with exValid=0 bubbles; consumer accepted on the 3rd edge; stallCnt=2.
3. Load-use with FORWARD_EN=1: load idRd=2, idIsLoad=1, then consumer idRt=2 → stall=1 for 1 cycle. Same sequence with idIsLoad=0 → stall never asserts.
4. Flush vs hazard: producer idRd=4 in EX, consumer idRs=4 in decode, flush=1 → stall=0, next exValid=0, stallCnt unchanged.
5. WB-only match: writer idRd=6 followed by two independent instructions, then reader idRs=6 → stall=0 while wbRd=6, wbValid=1.
6. Saturation with CNT_W=2: force 5 stall cycles → stallCnt reads 1,2,3,3,3. Then rst=0 mid-stall → next cycle stall=0 and stallCnt=0.
